vga_sync_receiver: RTL and testbench

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

---
 rtl/vga_sync_receiver.sv | 167 ++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// Measures incoming VGA sync timing, produces pixel coordinates and tracks lock.
// Edges are found on once-registered pins; every output is registered.
module vga_sync_receiver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hs,
  input  logic       vs,
  input  logic       de,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic       pix_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] h_total,
  output logic [9:0] v_total,
  output logic       locked,
  output logic       sync_error
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  logic       hs_s1, hs_prev, vs_s1, vs_prev, de_s1, de_prev;
  logic       hs_fall, vs_fall, de_rise, de_fall;
  logic [9:0] h_cnt, v_cnt, x_cnt, x_next;
  logic [8:0] y_cnt;
  logic       h_sat, v_sat, h_miss, v_miss, lock_err, meas_clean;
  state_t     state;
  logic [9:0] ref_h, ref_v;
  logic       ref_valid, v_seen, meas_bad;

  // Syncs idle high and de idles low, so reset release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_s1   <= 1'b1;
      hs_prev <= 1'b1;
      vs_s1   <= 1'b1;
      vs_prev <= 1'b1;
      de_s1   <= 1'b0;
      de_prev <= 1'b0;
    end else begin
      hs_s1   <= hs;
      hs_prev <= hs_s1;
      vs_s1   <= vs;
      vs_prev <= vs_s1;
      de_s1   <= de;
      de_prev <= de_s1;
    end
  end

  assign hs_fall = hs_prev & ~hs_s1;
  assign vs_fall = vs_prev & ~vs_s1;
  assign de_rise = de_s1 & ~de_prev;
  assign de_fall = de_prev & ~de_s1;

  // Counters restart at 1 so the captured value is the full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_total     <= '0;
      v_total     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= hs_fall;
      frame_start <= vs_fall;
      if (hs_fall) begin
        h_cnt   <= 10'd1;
        h_total <= h_cnt;
      end else if (h_cnt != 10'd1023) begin
        h_cnt <= h_cnt + 10'd1;
      end
      if (vs_fall) begin
        v_cnt   <= 10'd1;
        v_total <= v_cnt;
      end else if (hs_fall && v_cnt != 10'd1023) begin
        v_cnt <= v_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    x_next = de_rise ? 10'd0 : ((x_cnt == 10'd1023) ? x_cnt : x_cnt + 10'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_valid <= 1'b0;
    end else begin
      if (de_s1) x_cnt <= x_next;
      if (vs_fall) y_cnt <= '0;
      else if (de_fall && y_cnt != 9'd511) y_cnt <= y_cnt + 9'd1;
      pix_valid <= de_s1;
      pix_x     <= de_s1 ? x_next : 10'd0;
      pix_y     <= de_s1 ? y_cnt : 9'd0;
    end
  end

  assign h_sat      = (h_cnt == 10'd1023) && !hs_fall;
  assign v_sat      = (v_cnt == 10'd1023) && !vs_fall;
  assign h_miss     = hs_fall && (h_cnt != ref_h);
  assign v_miss     = vs_fall && (v_cnt != ref_v);
  assign lock_err   = h_miss || v_miss || h_sat || v_sat;
  assign meas_clean = ref_valid && !meas_bad && !h_miss && !h_sat && !v_sat;

  // MEASURE needs one clean frame to learn the line count and a second to confirm it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      ref_h      <= '0;
      ref_v      <= '0;
      ref_valid  <= 1'b0;
      v_seen     <= 1'b0;
      meas_bad   <= 1'b0;
      locked     <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      sync_error <= 1'b0;
      case (state)
        SEARCH: begin
          if (vs_fall) begin
            state     <= MEASURE;
            ref_valid <= 1'b0;
            v_seen    <= 1'b0;
            meas_bad  <= 1'b0;
          end
        end
        MEASURE: begin
          if (vs_fall) begin
            meas_bad <= 1'b0;
            if (!meas_clean) begin
              ref_valid <= 1'b0;
              v_seen    <= 1'b0;
            end else if (v_seen && v_cnt == ref_v) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              v_seen <= 1'b1;
              ref_v  <= v_cnt;
            end
          end else if (hs_fall && !ref_valid) begin
            ref_h     <= h_cnt;
            ref_valid <= 1'b1;
          end else if (h_miss || h_sat || v_sat) begin
            meas_bad <= 1'b1;
          end
        end
        LOCKED: begin
          if (lock_err) begin
            state      <= SEARCH;
            locked     <= 1'b0;
            sync_error <= 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Self-checking bench for vga_sync_receiver: randomized scaled-down video timing
// compared against an intended-pixel model, plus directed lock/error/reset steps.
module tb_vga_sync_receiver;

  localparam int HS_W  = 12;
  localparam int LIMIT = 50000;

  typedef struct packed {
    logic       vis;
    logic [9:0] col;
    logic [8:0] row;
    logic       ls;
    logic       fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs = 1'b1, vs = 1'b1, de = 1'b0;
  logic [9:0] pix_x, h_total, v_total;
  logic [8:0] pix_y;
  logic       pix_valid, line_start, frame_start, locked, sync_error;

  exp_t cur = '0, p1, p2;
  int   n_checks = 0, n_pass = 0, n_fail = 0, err_pulses = 0;
  int   line_len, frame_lines, ax0, aw, ay0, ah;
  int   pos_c = 0, pos_line = 0, cur_len = 0;
  int   ovr_line = 0, ovr_len = 0;
  bit   ovr_pending = 1'b0;

  vga_sync_receiver dut (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .de(de),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .line_start(line_start), .frame_start(frame_start),
    .h_total(h_total), .v_total(v_total),
    .locked(locked), .sync_error(sync_error)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Whatever the pins carried two clocks ago is what the outputs must show now.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      p1 <= cur;
      p2 <= p1;
    end
  end

  always @(negedge clk) begin
    check_output("pix_valid", pix_valid, p2.vis);
    check_output("pix_x", pix_x, p2.col);
    check_output("pix_y", pix_y, p2.row);
    check_output("line_start", line_start, p2.ls);
    check_output("frame_start", frame_start, p2.fs);
    if (sync_error) err_pulses++;
  end

  task automatic step();
    bit vis;
    @(negedge clk);
    if (pos_c == 0) begin
      cur_len = line_len;
      if (ovr_pending && pos_line == ovr_line) begin
        cur_len     = ovr_len;
        ovr_pending = 1'b0;
      end
    end
    vis = (pos_line >= ay0) && (pos_line < ay0 + ah) && (pos_c >= ax0) && (pos_c < ax0 + aw);
    hs  = (pos_c < HS_W) ? 1'b0 : 1'b1;
    vs  = (pos_line < 2) ? 1'b0 : 1'b1;
    de  = vis;
    cur.vis = vis;
    cur.col = vis ? 10'(pos_c - ax0) : 10'd0;
    cur.row = vis ? 9'(pos_line - ay0) : 9'd0;
    cur.ls  = (pos_c == 0);
    cur.fs  = (pos_c == 0) && (pos_line == 0);
    pos_c++;
    if (pos_c == cur_len) begin
      pos_c = 0;
      pos_line++;
      if (pos_line == frame_lines) pos_line = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step_idle();
    @(negedge clk);
    hs  = 1'b1;
    vs  = 1'b1;
    de  = 1'b0;
    cur = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int line, input int col);
    int guard = 0;
    while (!(pos_line == line && pos_c == col) && guard < LIMIT) begin
      step();
      guard++;
    end
    check_output("run_to_bound", guard < LIMIT, 1'b1);
  endtask

  // Lock must appear exactly two clocks after the third frame-start pin edge.
  task automatic apply_lock_sequence(input string tag);
    run_to(0, 0); step(); step();
    check_output({tag, "_f1_locked"}, locked, 1'b0);
    run_to(0, 0); step(); step();
    check_output({tag, "_f2_locked"}, locked, 1'b0);
    check_output({tag, "_h_total"}, h_total, 10'(line_len));
    check_output({tag, "_v_total"}, v_total, 10'(frame_lines));
    run_to(0, 0); step();
    check_output({tag, "_f3_early"}, locked, 1'b0);
    step();
    check_output({tag, "_f3_locked"}, locked, 1'b1);
    check_output({tag, "_f3_pulses"}, {line_start, frame_start}, 2'b11);
    check_output({tag, "_f3_sync_error"}, sync_error, 1'b0);
  endtask

  initial begin
    int sl, ll, rl, rc;
    line_len    = $urandom_range(80, 140);
    frame_lines = $urandom_range(10, 14);
    ax0         = $urandom_range(16, 30);
    aw          = $urandom_range(40, line_len - ax0 - 4);
    ay0         = $urandom_range(2, 4);
    ah          = $urandom_range(3, frame_lines - ay0 - 1);
    cur_len     = line_len;
    $display("[TB] line=%0d frame=%0d active x%0d+%0d y%0d+%0d", line_len, frame_lines, ax0, aw, ay0, ah);

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_h_total", h_total, 10'd0);
    check_output("rst_v_total", v_total, 10'd0);
    check_output("rst_locked", locked, 1'b0);
    check_output("rst_sync_error", sync_error, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat ($urandom_range(1, 5)) step_idle();

    apply_lock_sequence("lock");

    // One more frame while locked: still locked, no errors, totals steady.
    run_to(0, 0); step(); step();
    check_output("steady_locked", locked, 1'b1);
    check_output("steady_h_total", h_total, 10'(line_len));
    check_output("steady_v_total", v_total, 10'(frame_lines));
    check_output("steady_err_pulses", err_pulses, 0);

    // A single line one clock short breaks lock at its closing edge.
    sl = $urandom_range(3, frame_lines - 3);
    ovr_line = sl; ovr_len = line_len - 1; ovr_pending = 1'b1;
    run_to(sl + 1, 0); step(); step();
    check_output("short_sync_error", sync_error, 1'b1);
    check_output("short_locked", locked, 1'b0);
    check_output("short_h_total", h_total, 10'(line_len - 1));
    step();
    check_output("short_err_once", sync_error, 1'b0);
    apply_lock_sequence("relock_short");
    check_output("short_err_pulses", err_pulses, 1);

    // hs stuck high long enough for the line counter to saturate.
    ll = $urandom_range(3, frame_lines - 3);
    ovr_line = ll; ovr_len = 1100; ovr_pending = 1'b1;
    run_to(ll + 1, 0);
    check_output("long_locked", locked, 1'b0);
    check_output("long_err_pulses", err_pulses, 2);
    step(); step();
    check_output("long_h_total", h_total, 10'd1023);
    apply_lock_sequence("relock_long");
    check_output("long_err_total", err_pulses, 2);

    // Asynchronous reset in the middle of a line while locked.
    rl = $urandom_range(2, frame_lines - 2);
    rc = $urandom_range(1, line_len - 2);
    run_to(rl, rc);
    check_output("pre_reset_locked", locked, 1'b1);
    @(negedge clk);
    hs = 1'b1; vs = 1'b1; de = 1'b0; cur = '0;
    #2 rst_n = 1'b0;
    #1;
    check_output("async_locked", locked, 1'b0);
    check_output("async_h_total", h_total, 10'd0);
    check_output("async_v_total", v_total, 10'd0);
    check_output("async_pix", {pix_valid, pix_x, pix_y}, 20'd0);
    check_output("async_pulses", {line_start, frame_start, sync_error}, 3'd0);
    repeat (3) step_idle();
    @(negedge clk);
    rst_n = 1'b1;
    pos_c = 0; pos_line = 0;
    for (int i = 0; i < 4; i++) begin
      step_idle();
      check_output("release_no_line_start", line_start, 1'b0);
    end
    check_output("release_h_total", h_total, 10'd0);
    apply_lock_sequence("relock_reset");
    check_output("final_err_pulses", err_pulses, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
